// File: rtl/progmem_arbiter_pkg.sv
// Shared constants and helpers for the program-memory front end.
// Widths follow the build-wide default values.
package progmem_arbiter_pkg;

    localparam int INST_W = 32;

    localparam int INST_ADDR_W = 10;

    localparam int N_CORES_DEFAULT = 4;

    // Round-robin successor of a core index.
    function automatic int next_idx(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/progmem_arbiter_if.sv
// Core-fetch and program-memory signals of the shared instruction front end.
// The master modport is the arbiter's view; slave is the cores/memory side.
interface progmem_arbiter_if
    import progmem_arbiter_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEFAULT
);
    logic                           en;
    logic [N_CORES-1:0]             core_req;
    logic [N_CORES*INST_ADDR_W-1:0] core_addr;
    logic [N_CORES*INST_W-1:0]      core_data;
    logic [N_CORES-1:0]             core_en;
    logic                           mem_rd;
    logic [INST_ADDR_W-1:0]         mem_addr;
    logic [INST_W-1:0]              mem_data;

    modport master (
        input  en, core_req, core_addr, mem_data,
        output core_data, core_en, mem_rd, mem_addr
    );

    modport slave (
        output en, core_req, core_addr, mem_data,
        input  core_data, core_en, mem_rd, mem_addr
    );
endinterface

// File: rtl/progmem_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
// Kept generic so the data-memory side can reuse it.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_id,
    output logic          any
);
    logic [PW-1:0] cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                gnt_id = cand;
                any    = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign gnt[gi] = any && (gnt_id == PW'(gi));
    end
endmodule

// File: rtl/progmem_arbiter.sv
// Shared instruction-memory front end: one round-robin read issued per cycle,
// word returned the next cycle with a one-hot enable pulse to the owning core.
module progmem_arbiter
    import progmem_arbiter_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEFAULT
) (
    input logic clk,
    input logic rst,
    progmem_arbiter_if.master bus
);
    localparam int PW = $clog2(N_CORES);

    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]          resp_id_q, resp_id_d;
    logic                   resp_valid_q, resp_valid_d;

    logic [N_CORES-1:0]     resp_onehot;
    logic [N_CORES-1:0]     eligible;
    logic [N_CORES-1:0]     gnt;
    logic [PW-1:0]          gnt_id;
    logic                   any;
    logic                   grant;
    logic [INST_ADDR_W-1:0] addr_mux;
    logic [N_CORES-1:0]     core_en_w;
    logic [N_CORES*INST_W-1:0] core_data_w;

    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core
        assign resp_onehot[gi] = resp_valid_q && (resp_id_q == PW'(gi));
        assign core_en_w[gi]   = resp_onehot[gi] && !rst;
        assign core_data_w[gi*INST_W +: INST_W] = bus.mem_data;
    end

    // The responding core's address moves after this edge, so it sits out a cycle.
    assign eligible = bus.core_req & ~resp_onehot;

    rr_arbiter #(.N(N_CORES)) u_rr_arbiter (
        .req    (eligible),
        .ptr    (rr_ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    always_comb begin
        grant    = bus.en && !rst && any;
        addr_mux = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (gnt[i]) begin
                addr_mux = addr_mux | bus.core_addr[i*INST_ADDR_W +: INST_ADDR_W];
            end
        end

        rr_ptr_d     = rr_ptr_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = grant;
        if (grant) begin
            rr_ptr_d  = PW'(next_idx(int'(gnt_id), N_CORES));
            resp_id_d = gnt_id;
        end
    end

    assign bus.mem_rd    = grant;
    assign bus.mem_addr  = grant ? addr_mux : '0;
    assign bus.core_en   = core_en_w;
    assign bus.core_data = core_data_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
        end
    end
endmodule

// File: tb/tb_progmem_arbiter.sv
// Directed bench for progmem_arbiter with a one-cycle synchronous memory model.
module tb_progmem_arbiter;
    import progmem_arbiter_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    progmem_arbiter_if #(.N_CORES(N)) bus ();

    progmem_arbiter #(.N_CORES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [INST_W-1:0] mem_word(input logic [INST_ADDR_W-1:0] a);
        if (a == 10'h010) return 32'hDEADBEEF;
        return 32'hA500_0000 | {22'd0, a};
    endfunction

    always @(posedge clk) begin
        if (rst) bus.mem_data <= '0;
        else if (bus.mem_rd) bus.mem_data <= mem_word(bus.mem_addr);
    end

    // 0x400 does not fit a 10-bit address, so the fourth core uses 0x3FF.
    logic [INST_ADDR_W-1:0] a [N];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.core_req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_addrs;
        bus.core_addr = {a[3], a[2], a[1], a[0]};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.en = 1'b1;
        bus.core_req = 4'b1111;
        set_addrs();
        tick();
        tick();
        n_vec++;
        if (bus.mem_rd !== 1'b0) begin
            n_err++; $display("FAIL reset_mem_rd got=%b want=0", bus.mem_rd);
        end
        n_vec++;
        if (bus.mem_addr !== '0) begin
            n_err++; $display("FAIL reset_mem_addr got=%h want=000", bus.mem_addr);
        end
        n_vec++;
        if (bus.core_en !== 4'b0000) begin
            n_err++; $display("FAIL reset_core_en got=%b want=0000", bus.core_en);
        end
        n_vec++;
        if (bus.core_data !== {(N*INST_W){1'b0}}) begin
            n_err++; $display("FAIL reset_core_data got=%h want=0", bus.core_data);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_core;
        do_reset();
        bus.en = 1'b1;
        bus.core_req = 4'b0001;
        bus.core_addr = '0;
        bus.core_addr[9:0] = 10'h010;
        #1;
        n_vec++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 10'h010) begin
            n_err++; $display("FAIL single_issue got rd=%b addr=%h want rd=1 addr=010", bus.mem_rd, bus.mem_addr);
        end
        tick();
        n_vec++;
        if (bus.core_en !== 4'b0001 || bus.mem_rd !== 1'b0) begin
            n_err++; $display("FAIL single_resp got en=%b rd=%b want en=0001 rd=0", bus.core_en, bus.mem_rd);
        end
        n_vec++;
        if (bus.core_data[31:0] !== 32'hDEADBEEF || bus.core_data[127:96] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL single_data got=%h want=DEADBEEF broadcast", bus.core_data);
        end
        bus.core_addr[9:0] = 10'h011;
        tick();
        n_vec++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 10'h011 || bus.core_en !== 4'b0000) begin
            n_err++; $display("FAIL single_reissue got rd=%b addr=%h en=%b want rd=1 addr=011 en=0000",
                              bus.mem_rd, bus.mem_addr, bus.core_en);
        end
        tick();
        n_vec++;
        if (bus.core_en !== 4'b0001 || bus.core_data[31:0] !== 32'hA500_0011) begin
            n_err++; $display("FAIL single_resp2 got en=%b data=%h want en=0001 data=A5000011",
                              bus.core_en, bus.core_data[31:0]);
        end
        $display("test_single_core done");
    endtask

    task automatic test_all_four;
        logic [3:0] exp_en;
        int g;
        int r;
        do_reset();
        bus.en = 1'b1;
        bus.core_req = 4'b1111;
        set_addrs();
        for (int k = 0; k < 8; k++) begin
            #1;
            g = k % 4;
            r = (k + 3) % 4;
            exp_en = (k == 0) ? 4'b0000 : 4'(1 << r);
            $display("all4 cyc %0d rd=%b addr=%h en=%b", k, bus.mem_rd, bus.mem_addr, bus.core_en);
            n_vec++;
            if (bus.mem_rd !== 1'b1 || bus.mem_addr !== a[g]) begin
                n_err++; $display("FAIL all4_issue cyc=%0d got rd=%b addr=%h want rd=1 addr=%h",
                                  k, bus.mem_rd, bus.mem_addr, a[g]);
            end
            n_vec++;
            if (bus.core_en !== exp_en) begin
                n_err++; $display("FAIL all4_en cyc=%0d got=%b want=%b", k, bus.core_en, exp_en);
            end
            if (k > 0) begin
                n_vec++;
                if (bus.core_data[r*INST_W +: INST_W] !== mem_word(a[r])) begin
                    n_err++; $display("FAIL all4_data cyc=%0d got=%h want=%h",
                                      k, bus.core_data[r*INST_W +: INST_W], mem_word(a[r]));
                end
            end
            tick();
        end
    endtask

    task automatic test_two_cores;
        logic [3:0] exp_en;
        int g;
        do_reset();
        bus.en = 1'b1;
        bus.core_req = 4'b0110;
        set_addrs();
        for (int k = 0; k < 6; k++) begin
            #1;
            g = (k % 2 == 0) ? 1 : 2;
            exp_en = (k == 0) ? 4'b0000 : ((k % 2 == 1) ? 4'b0010 : 4'b0100);
            $display("two cyc %0d rd=%b addr=%h en=%b", k, bus.mem_rd, bus.mem_addr, bus.core_en);
            n_vec++;
            if (bus.mem_rd !== 1'b1 || bus.mem_addr !== a[g]) begin
                n_err++; $display("FAIL two_issue cyc=%0d got rd=%b addr=%h want rd=1 addr=%h",
                                  k, bus.mem_rd, bus.mem_addr, a[g]);
            end
            n_vec++;
            if (bus.core_en !== exp_en) begin
                n_err++; $display("FAIL two_en cyc=%0d got=%b want=%b", k, bus.core_en, exp_en);
            end
            tick();
        end
    endtask

    task automatic test_en_low;
        do_reset();
        bus.en = 1'b1;
        bus.core_req = 4'b1111;
        set_addrs();
        tick();
        tick();
        #1;
        n_vec++;
        if (bus.mem_addr !== a[2]) begin
            n_err++; $display("FAIL enlow_grant2 got addr=%h want=%h", bus.mem_addr, a[2]);
        end
        tick();
        bus.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (bus.mem_rd !== 1'b0 || bus.core_en !== ((k == 0) ? 4'b0100 : 4'b0000)) begin
                n_err++; $display("FAIL enlow_hold cyc=%0d got rd=%b en=%b want rd=0 en=%b",
                                  k, bus.mem_rd, bus.core_en, (k == 0) ? 4'b0100 : 4'b0000);
            end
            tick();
        end
        bus.en = 1'b1;
        #1;
        n_vec++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== a[3] || bus.core_en !== 4'b0000) begin
            n_err++; $display("FAIL enlow_resume got rd=%b addr=%h en=%b want rd=1 addr=%h en=0000",
                              bus.mem_rd, bus.mem_addr, bus.core_en, a[3]);
        end
        tick();
        n_vec++;
        if (bus.core_en !== 4'b1000) begin
            n_err++; $display("FAIL enlow_resume_en got=%b want=1000", bus.core_en);
        end
        $display("test_en_low done");
    endtask

    task automatic test_reset_inflight;
        do_reset();
        bus.en = 1'b1;
        bus.core_req = 4'b1111;
        set_addrs();
        tick();
        #1;
        n_vec++;
        if (bus.mem_addr !== a[1]) begin
            n_err++; $display("FAIL rstfl_grant1 got addr=%h want=%h", bus.mem_addr, a[1]);
        end
        tick();
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.core_en !== 4'b0000 || bus.mem_rd !== 1'b0) begin
            n_err++; $display("FAIL rstfl_during got en=%b rd=%b want en=0000 rd=0", bus.core_en, bus.mem_rd);
        end
        tick();
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.core_en !== 4'b0000 || bus.mem_rd !== 1'b1 || bus.mem_addr !== a[0]) begin
            n_err++; $display("FAIL rstfl_after got en=%b rd=%b addr=%h want en=0000 rd=1 addr=%h",
                              bus.core_en, bus.mem_rd, bus.mem_addr, a[0]);
        end
        tick();
        n_vec++;
        if (bus.core_en !== 4'b0001) begin
            n_err++; $display("FAIL rstfl_first_en got=%b want=0001", bus.core_en);
        end
        $display("test_reset_inflight done");
    endtask

    task automatic test_idle;
        do_reset();
        bus.en = 1'b1;
        bus.core_req = 4'b0010;
        set_addrs();
        tick();
        bus.core_req = 4'b0000;
        #1;
        n_vec++;
        if (bus.core_en !== 4'b0010) begin
            n_err++; $display("FAIL idle_drop_resp got=%b want=0010", bus.core_en);
        end
        tick();
        for (int k = 0; k < 10; k++) begin
            n_vec++;
            if (bus.mem_rd !== 1'b0 || bus.core_en !== 4'b0000) begin
                n_err++; $display("FAIL idle cyc=%0d got rd=%b en=%b want rd=0 en=0000",
                                  k, bus.mem_rd, bus.core_en);
            end
            tick();
        end
        bus.core_req = 4'b1111;
        #1;
        n_vec++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== a[2]) begin
            n_err++; $display("FAIL idle_ptr got rd=%b addr=%h want rd=1 addr=%h",
                              bus.mem_rd, bus.mem_addr, a[2]);
        end
        $display("test_idle done");
    endtask

    initial begin
        a[0] = 10'h100;
        a[1] = 10'h200;
        a[2] = 10'h300;
        a[3] = 10'h3FF;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.core_req = '0;
        bus.core_addr = '0;
        test_reset();
        test_single_core();
        test_all_four();
        test_two_cores();
        test_en_low();
        test_reset_inflight();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
